// File: rtl/ddr2_data_read_0_pkg.sv
// Shared constants, FSM encoding and FIFO entry sizing for the DDR2 read data path.
`default_nettype none

package ddr2_data_read_0_pkg;

    localparam int RD_LAT_WIDTH = 4;
    localparam int RD_DLY_DEPTH = 16;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } rd_state_t;

    // One FIFO entry holds {rise, fall, last}.
    function automatic int fifo_entry_width(input int dq_width);
        return 2 * dq_width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ddr2_rd_fifo_0.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers.
`default_nettype none

module ddr2_rd_fifo_0 #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/ddr2_data_read_0.sv
// DDR2 read data path: latency-matched read enable, burst capture FSM, FWFT output FIFO.
// Optional burst counter output rd_burst_cnt when DDR2_RD_STATS_EN is defined.
`default_nettype none

module ddr2_data_read_0
    import ddr2_data_read_0_pkg::*;
#(
    parameter int DQ_WIDTH   = 16,
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ctrl_rden,
    input  logic [RD_LAT_WIDTH-1:0] rd_lat,
    input  logic [DQ_WIDTH-1:0]     rd_data_rise,
    input  logic [DQ_WIDTH-1:0]     rd_data_fall,
    input  logic                    user_rd_ready,
    output logic                    user_rd_valid,
    output logic [2*DQ_WIDTH-1:0]   user_rd_data,
    output logic                    user_rd_last,
    output logic                    rd_overflow,
    output logic                    rd_err
`ifdef DDR2_RD_STATS_EN
    ,
    output logic [15:0]             rd_burst_cnt
`endif
);

    localparam int BEATS   = BURST_LEN / 2;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ENTRY_W = fifo_entry_width(DQ_WIDTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [RD_DLY_DEPTH-1:0] rden_dly;
    logic [RD_DLY_DEPTH:0]   rden_taps;
    logic [RD_LAT_WIDTH:0]   tap_sel;
    logic                    rd_start;
    rd_state_t               state;
    logic [BEAT_W-1:0]       beat;
    logic                    capture;
    logic                    final_beat;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ENTRY_W-1:0]      fifo_out;

    // rd_start is registered and the FSM adds one more cycle, so tap rd_lat-1
    // puts the first beat at ctrl_rden + rd_lat + 1; rd_lat=0 behaves as 1.
    assign rden_taps = {rden_dly, ctrl_rden};
    assign tap_sel   = (rd_lat == '0) ? '0 : ({1'b0, rd_lat} - 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rden_dly <= '0;
            rd_start <= 1'b0;
        end else begin
            rden_dly <= {rden_dly[RD_DLY_DEPTH-2:0], ctrl_rden};
            rd_start <= rden_taps[tap_sel];
        end
    end

    assign capture    = (state == CAPTURE);
    assign final_beat = capture && (beat == LAST_BEAT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            beat   <= '0;
            rd_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_start) begin
                        state <= CAPTURE;
                        beat  <= '0;
                    end
                end
                CAPTURE: begin
                    if (beat == LAST_BEAT) begin
                        beat <= '0;
                        if (!rd_start) state <= IDLE;
                    end else begin
                        beat <= beat + 1'b1;
                        if (rd_start) rd_err <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign pop = user_rd_valid && user_rd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_overflow <= 1'b0;
        end else if (capture && fifo_full && !pop) begin
            rd_overflow <= 1'b1;
        end
    end

`ifdef DDR2_RD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_burst_cnt <= '0;
        end else if (final_beat) begin
            rd_burst_cnt <= rd_burst_cnt + 16'd1;
        end
    end
`endif

    ddr2_rd_fifo_0 #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data ({rd_data_rise, rd_data_fall, final_beat}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign user_rd_valid = !fifo_empty;
    assign user_rd_data  = fifo_out[ENTRY_W-1:1];
    assign user_rd_last  = fifo_out[0];

endmodule

`default_nettype wire
